// File: rtl/pulse_stretcher_if.sv
// Signal bundle between a trigger source and pulse_stretcher.
// master: drives the trigger strobe and configuration, observes the pulse.
// slave:  the stretcher itself.
interface pulse_stretcher_if #(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
);
  logic              trigger;
  logic [CNT_W-1:0]  delay_cfg;
  logic [CNT_W-1:0]  width_cfg;
  logic [CNT_W-1:0]  holdoff_cfg;
  logic              pulse_out;
  logic              busy;
  logic              done;
  logic [MISS_W-1:0] miss_cnt;

  modport master (
    output trigger, delay_cfg, width_cfg, holdoff_cfg,
    input  pulse_out, busy, done, miss_cnt
  );

  modport slave (
    input  trigger, delay_cfg, width_cfg, holdoff_cfg,
    output pulse_out, busy, done, miss_cnt
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a single-cycle trigger into a delayed pulse of
// programmable width followed by a programmable dead time.
// Optional feature macro RETRIGGER_EN: when defined, a trigger during the
// pulse restarts the width count instead of being counted as a miss.
module pulse_stretcher #(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  pulse_stretcher_if.slave bus
);

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic [CNT_W-1:0]  width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  width_lat_q, width_lat_d;
  logic [CNT_W-1:0]  hold_lat_q, hold_lat_d;
  logic              pulse_q, pulse_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              miss_evt;
  logic [CNT_W-1:0]  w_eff;

  // A zero width request still produces a one-cycle pulse.
  assign w_eff = (bus.width_cfg == CNT_ZERO) ? CNT_ONE : bus.width_cfg;

  // State, counters, latched configuration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      delay_cnt_q <= '0;
      width_cnt_q <= '0;
      hold_cnt_q  <= '0;
      width_lat_q <= '0;
      hold_lat_q  <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      width_cnt_q <= width_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      width_lat_q <= width_lat_d;
      hold_lat_q  <= hold_lat_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
    end
  end

  // Next-state and counter logic; counters run down to 1 and then stop.
  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    width_cnt_d = width_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    width_lat_d = width_lat_q;
    hold_lat_d  = hold_lat_q;
    miss_evt    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          width_lat_d = w_eff;
          hold_lat_d  = bus.holdoff_cfg;
          if (bus.delay_cfg == CNT_ZERO) begin
            state_d     = ACTIVE;
            width_cnt_d = w_eff;
          end else begin
            state_d     = DELAY;
            delay_cnt_d = bus.delay_cfg;
          end
        end
      end
      DELAY: begin
        miss_evt = bus.trigger;
        if (delay_cnt_q <= CNT_ONE) begin
          state_d     = ACTIVE;
          delay_cnt_d = CNT_ZERO;
          width_cnt_d = width_lat_q;
        end else begin
          delay_cnt_d = delay_cnt_q - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (bus.trigger && RETRIG) begin
          // Restart: W more cycles counted from the next cycle.
          width_cnt_d = w_eff;
        end else begin
          miss_evt = bus.trigger;
          if (width_cnt_q <= CNT_ONE) begin
            width_cnt_d = CNT_ZERO;
            if (hold_lat_q != CNT_ZERO) begin
              state_d    = HOLDOFF;
              hold_cnt_d = hold_lat_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            width_cnt_d = width_cnt_q - CNT_ONE;
          end
        end
      end
      HOLDOFF: begin
        miss_evt = bus.trigger;
        if (hold_cnt_q <= CNT_ONE) begin
          state_d    = IDLE;
          hold_cnt_d = CNT_ZERO;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values derived from the upcoming state.
  always_comb begin
    pulse_d = (state_d == ACTIVE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == ACTIVE) && (state_d != ACTIVE);
    miss_d  = miss_q;
    if (miss_evt && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + MISS_ONE;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.miss_cnt  = miss_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios plus random
// triggers/configuration, compared against a timestamp-based reference model.
module tb_pulse_stretcher;
  localparam int CNT_W  = 16;
  localparam int MISS_W = 2;
  localparam int MISS_SAT = (1 << MISS_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.CNT_W(CNT_W), .MISS_W(MISS_W)) bus_if ();

  pulse_stretcher #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int hi_cnt = 0;

  // Reference model: absolute cycle numbers of the current pulse.
  int acc_c, start_c, pend_c, last_busy_c, hold_m, miss_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    acc_c = -100; start_c = -100; pend_c = -101; last_busy_c = -100;
    hold_m = 0; miss_m = 0;
  endtask

  task automatic model_trigger(input int d, input int w, input int h);
    int w1;
    w1 = (w == 0) ? 1 : w;
    if (cyc > last_busy_c) begin
      acc_c = cyc; start_c = cyc + 1 + d; pend_c = start_c + w1 - 1;
      hold_m = h; last_busy_c = pend_c + h;
      $display("cyc %0d trigger accepted d=%0d w=%0d h=%0d", cyc, d, w, h);
    end
`ifdef RETRIGGER_EN
    else if (cyc >= start_c && cyc <= pend_c) begin
      pend_c = cyc + w1; last_busy_c = pend_c + hold_m;
      $display("cyc %0d trigger retriggered w=%0d", cyc, w);
    end
`endif
    else begin
      if (miss_m < MISS_SAT) miss_m++;
      $display("cyc %0d trigger rejected miss=%0d", cyc, miss_m);
    end
  endtask

  // Positioned at a falling edge: check this cycle, drive inputs, advance one cycle.
  task automatic cycle(input logic trig, input int d, input int w, input int h);
    check_eq("pulse_out", 32'(bus_if.pulse_out), 32'(cyc >= start_c && cyc <= pend_c));
    check_eq("busy", 32'(bus_if.busy), 32'(cyc > acc_c && cyc <= last_busy_c));
    check_eq("done", 32'(bus_if.done), 32'(cyc == pend_c + 1));
    check_eq("miss_cnt", 32'(bus_if.miss_cnt), 32'(miss_m));
    if (bus_if.pulse_out === 1'b1) hi_cnt++;
    bus_if.trigger     = trig;
    bus_if.delay_cfg   = CNT_W'(d);
    bus_if.width_cfg   = CNT_W'(w);
    bus_if.holdoff_cfg = CNT_W'(h);
    if (trig) model_trigger(d, w, h);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
  endtask

  // Positioned at a falling edge: assert reset, check async effect, release.
  task automatic do_reset();
    rst = 1'b1;
    bus_if.trigger = 1'b0;
    #1;
    check_eq("rst_pulse", 32'(bus_if.pulse_out), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_done", 32'(bus_if.done), 32'd0);
    check_eq("rst_miss", 32'(bus_if.miss_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    check_eq("rst_done_hold", 32'(bus_if.done), 32'd0);
    rst = 1'b0;
    hi_cnt = 0;
  endtask

  initial begin
    bus_if.trigger = 1'b0;
    bus_if.delay_cfg = '0;
    bus_if.width_cfg = '0;
    bus_if.holdoff_cfg = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Trigger on the first edge after reset: delay 0, width 5, no holdoff.
    cycle(1'b1, 0, 5, 0);
    idle(8);
    check_eq("w5_len", 32'(hi_cnt), 32'd5);

    // delay 3, width 2, holdoff 4; trigger in last holdoff cycle then first idle.
    do_reset();
    cycle(1'b1, 3, 2, 4);
    idle(8);
    cycle(1'b1, 3, 2, 4);
    cycle(1'b1, 3, 2, 4);
    idle(12);
    check_eq("holdoff_edge_miss", 32'(bus_if.miss_cnt), 32'd1);
    check_eq("holdoff_edge_len", 32'(hi_cnt), 32'd4);

    // width 0 gives one cycle; width change during delay is ignored.
    do_reset();
    cycle(1'b1, 0, 0, 0);
    idle(3);
    check_eq("w0_len", 32'(hi_cnt), 32'd1);
    hi_cnt = 0;
    cycle(1'b1, 4, 3, 0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 0, 9, 0);
    check_eq("latched_w_len", 32'(hi_cnt), 32'd3);

    // Five triggers in holdoff saturate a 2-bit miss counter.
    do_reset();
    cycle(1'b1, 0, 1, 10);
    idle(1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 0, 1, 10);
    idle(8);
    check_eq("miss_sat", 32'(bus_if.miss_cnt), 32'd3);

    // Trigger during the pulse.
    do_reset();
    cycle(1'b1, 0, 4, 0);
    idle(1);
    cycle(1'b1, 0, 4, 0);
    idle(8);
`ifdef RETRIGGER_EN
    check_eq("active_trig_len", 32'(hi_cnt), 32'd6);
    check_eq("active_trig_miss", 32'(bus_if.miss_cnt), 32'd0);
`else
    check_eq("active_trig_len", 32'(hi_cnt), 32'd4);
    check_eq("active_trig_miss", 32'(bus_if.miss_cnt), 32'd1);
`endif

    // Reset in the middle of a width-10 pulse.
    do_reset();
    cycle(1'b1, 0, 10, 0);
    idle(1);
    check_eq("pre_rst_pulse", 32'(bus_if.pulse_out), 32'd1);
    do_reset();
    idle(3);
    cycle(1'b1, 0, 2, 1);
    idle(6);
    check_eq("post_rst_len", 32'(hi_cnt), 32'd2);

    // Random triggers with configuration changing every cycle.
    for (int ep = 0; ep < 20; ep++) begin
      if ((ep % 3) == 0) do_reset();
      for (int i = 0; i < 60; i++) begin
        cycle(($urandom_range(0, 4) == 0), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter CNT_W, default 16: width of the delay, width and holdoff configuration inputs and their counters.
REQ-002 Parameter MISS_W, default 8: width of the missed-trigger counter.
REQ-003 Port clk, input, 1: single system clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port trigger, input, 1: single-cycle strobe from the upstream edge-detect/synchroniser stage, synchronous to clk.
REQ-006 Port delay_cfg, input, CNT_W: cycles from accepted trigger to pulse start.
REQ-007 Port width_cfg, input, CNT_W: stretched pulse length in cycles.
REQ-008 Port holdoff_cfg, input, CNT_W: dead-time cycles after pulse end.
REQ-009 Port pulse_out, output, 1: stretched pulse, registered.
REQ-010 Port busy, output, 1: high whenever state is not IDLE.
REQ-011 Port done, output, 1: one-cycle strobe marking the end of a pulse.
REQ-012 Port miss_cnt, output, MISS_W: saturating count of triggers that were not accepted.

Function
REQ-013 The block SHALL implement the states IDLE, DELAY, ACTIVE and HOLDOFF, with every output driven from a register.
REQ-014 In IDLE, trigger=1 SHALL be accepted and SHALL latch width_cfg and holdoff_cfg; configuration changes after acceptance have no effect on that pulse.
REQ-015 When a trigger is accepted at cycle T with delay_cfg=0, the next state SHALL be ACTIVE and pulse_out SHALL be high from cycle T+1.
REQ-016 When a trigger is accepted at cycle T with delay_cfg=D>0, the next state SHALL be DELAY for D cycles, and pulse_out SHALL be high from cycle T+1+D.
REQ-017 pulse_out SHALL stay high for exactly W cycles, where W is the latched width_cfg; width_cfg=0 SHALL be treated as W=1.
REQ-018 After the last ACTIVE cycle the next state SHALL be HOLDOFF if the latched holdoff value H>0, otherwise IDLE.
REQ-019 done SHALL be high for exactly one cycle: the first cycle in which pulse_out is low after a pulse.
REQ-020 HOLDOFF SHALL last H cycles with pulse_out low and then return to IDLE.
REQ-021 A trigger in the last HOLDOFF cycle SHALL be rejected; a trigger in the first IDLE cycle SHALL be accepted.
REQ-022 A trigger seen in DELAY or HOLDOFF SHALL be rejected and SHALL increment miss_cnt by 1.
REQ-023 A trigger seen in ACTIVE SHALL be handled as defined in Configuration.
REQ-024 miss_cnt SHALL saturate at 2^MISS_W-1 and never wrap.
REQ-025 busy SHALL be 1 in DELAY, ACTIVE and HOLDOFF, and 0 in IDLE.
REQ-026 All counters SHALL be CNT_W wide, count down to 1, and never underflow.

Reset
REQ-027 While rst=1: state=IDLE, pulse_out=0, busy=0, done=0, miss_cnt=0, and all counters and latched configuration registers are 0.
REQ-028 Reset asserted mid-pulse SHALL force pulse_out low asynchronously, without asserting done.
REQ-029 The first trigger SHALL be acceptable on the first clk edge after rst deasserts.

Configuration
REQ-030 Macro RETRIGGER_EN defined: a trigger in ACTIVE SHALL reload the width counter with the current width_cfg, so pulse_out stays high for W more cycles counted from the next cycle; miss_cnt does not change.
REQ-031 Macro RETRIGGER_EN undefined: a trigger in ACTIVE SHALL be rejected, SHALL increment miss_cnt, and SHALL not alter pulse timing.

Verification
REQ-032 Trigger at T with delay=0, width=5, holdoff=0 -> pulse_out high T+1..T+5, done at T+6, busy low at T+6.
REQ-033 Trigger at T with delay=3, width=2, holdoff=4 -> pulse_out high T+4..T+5, done at T+6, busy high through T+9; a trigger at T+9 -> miss_cnt=1; a trigger at T+10 -> accepted.
REQ-034 width=0 -> one-cycle pulse; width_cfg changed to 9 during DELAY -> latched width is still used.
REQ-035 With MISS_W=2, 5 triggers during HOLDOFF -> miss_cnt=3 (saturated).
REQ-036 With width=4, trigger at T and a second trigger at T+2 -> RETRIGGER_EN: pulse_out high T+1..T+6; without the macro: pulse_out high T+1..T+4 and miss_cnt=1.
REQ-037 rst pulsed at T+2 of a width=10 pulse -> pulse_out low immediately, done never asserted, next trigger accepted normally.
